// File: rtl/sram_bus_bridge.sv
// sram_bus_bridge: serialises core inst/data SRAM requests onto one req/ack bus with kseg0/kseg1 translation
module sram_bus_bridge #(
  parameter bit KSEG_MAP = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_sram_en,
  input  logic [3:0]  inst_sram_wen,
  input  logic [31:0] inst_sram_addr,
  input  logic [31:0] inst_sram_wdata,
  output logic [31:0] inst_sram_rdata,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  output logic        stallreq_bus,
  output logic        bus_req,
  output logic        bus_wr,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_addr_ok,
  input  logic [31:0] bus_rdata,
  input  logic        bus_data_ok
);
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    D_REQ  = 3'd1,
    D_WAIT = 3'd2,
    I_REQ  = 3'd3,
    I_WAIT = 3'd4,
    DONE   = 3'd5
  } state_t;
  state_t state_q, state_d;
  logic        wr_q, wr_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
  logic [31:0] irdata_q, irdata_d, drdata_q, drdata_d;
  logic        load_d, load_i;
  logic        unused_ok;
  assign unused_ok = ^{inst_sram_wen, inst_sram_wdata};
  function automatic logic [31:0] xlate(input logic [31:0] a);
    return (KSEG_MAP && a[31:30] == 2'b10) ? {3'b000, a[28:0]} : a;
  endfunction
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = data_sram_en ? D_REQ : inst_sram_en ? I_REQ : IDLE;
      D_REQ:   state_d = bus_addr_ok ? D_WAIT : D_REQ;
      D_WAIT:  state_d = !bus_data_ok ? D_WAIT : inst_sram_en ? I_REQ : DONE;
      I_REQ:   state_d = bus_addr_ok ? I_WAIT : I_REQ;
      I_WAIT:  state_d = bus_data_ok ? DONE : I_WAIT;
      default: state_d = IDLE;
    endcase
  end
  // Request fields are captured once when a transaction is launched and then held.
  assign load_d = state_q == IDLE && data_sram_en;
  assign load_i = (state_q == IDLE && !data_sram_en && inst_sram_en) ||
                  (state_q == D_WAIT && bus_data_ok && inst_sram_en);
  always_comb begin
    wr_d     = load_d ? |data_sram_wen : load_i ? 1'b0 : wr_q;
    wstrb_d  = load_d ? data_sram_wen : load_i ? 4'b0 : wstrb_q;
    addr_d   = load_d ? xlate(data_sram_addr) : load_i ? xlate(inst_sram_addr) : addr_q;
    wdata_d  = load_d ? data_sram_wdata : load_i ? 32'b0 : wdata_q;
    drdata_d = (state_q == D_WAIT && bus_data_ok && !wr_q) ? bus_rdata : drdata_q;
    irdata_d = (state_q == I_WAIT && bus_data_ok) ? bus_rdata : irdata_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      wr_q     <= 1'b0;
      wstrb_q  <= 4'b0;
      addr_q   <= 32'b0;
      wdata_q  <= 32'b0;
      irdata_q <= 32'b0;
      drdata_q <= 32'b0;
    end else begin
      state_q  <= state_d;
      wr_q     <= wr_d;
      wstrb_q  <= wstrb_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      irdata_q <= irdata_d;
      drdata_q <= drdata_d;
    end
  end
  assign bus_req         = state_q == D_REQ || state_q == I_REQ;
  assign bus_wr          = wr_q;
  assign bus_wstrb       = wstrb_q;
  assign bus_addr        = addr_q;
  assign bus_wdata       = wdata_q;
  assign inst_sram_rdata = irdata_q;
  assign data_sram_rdata = drdata_q;
  // Only IDLE looks at the enables combinationally; DONE is the one-cycle release.
  assign stallreq_bus = !rst && ((state_q == IDLE && (inst_sram_en || data_sram_en)) ||
                                 (state_q != IDLE && state_q != DONE));
endmodule

// File: tb/tb_sram_bus_bridge.sv
// tb_sram_bus_bridge: directed self-checking bench for sram_bus_bridge
module tb_sram_bus_bridge;
  logic        clk = 1'b0, rst = 1'b1;
  logic        inst_sram_en = 1'b0, data_sram_en = 1'b0;
  logic [3:0]  inst_sram_wen = 4'hF, data_sram_wen = 4'b0;
  logic [31:0] inst_sram_addr = '0, inst_sram_wdata = 32'hFFFF_FFFF;
  logic [31:0] data_sram_addr = '0, data_sram_wdata = '0;
  logic        bus_addr_ok = 1'b0, bus_data_ok = 1'b0;
  logic [31:0] bus_rdata = '0;
  logic [31:0] inst_sram_rdata, data_sram_rdata, bus_addr, bus_wdata;
  logic        stallreq_bus, bus_req, bus_wr;
  logic [3:0]  bus_wstrb;
  logic [31:0] n_inst_sram_rdata, n_data_sram_rdata, n_bus_addr, n_bus_wdata;
  logic        n_stallreq_bus, n_bus_req, n_bus_wr;
  logic [3:0]  n_bus_wstrb;
  int n_cmp = 0, n_err = 0;
  always #5 clk = ~clk;
  sram_bus_bridge #(.KSEG_MAP(1'b1)) dut (
    .clk(clk), .rst(rst),
    .inst_sram_en(inst_sram_en), .inst_sram_wen(inst_sram_wen), .inst_sram_addr(inst_sram_addr),
    .inst_sram_wdata(inst_sram_wdata), .inst_sram_rdata(inst_sram_rdata),
    .data_sram_en(data_sram_en), .data_sram_wen(data_sram_wen), .data_sram_addr(data_sram_addr),
    .data_sram_wdata(data_sram_wdata), .data_sram_rdata(data_sram_rdata),
    .stallreq_bus(stallreq_bus), .bus_req(bus_req), .bus_wr(bus_wr), .bus_wstrb(bus_wstrb),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_addr_ok(bus_addr_ok),
    .bus_rdata(bus_rdata), .bus_data_ok(bus_data_ok)
  );
  sram_bus_bridge #(.KSEG_MAP(1'b0)) dut_nomap (
    .clk(clk), .rst(rst),
    .inst_sram_en(inst_sram_en), .inst_sram_wen(inst_sram_wen), .inst_sram_addr(inst_sram_addr),
    .inst_sram_wdata(inst_sram_wdata), .inst_sram_rdata(n_inst_sram_rdata),
    .data_sram_en(data_sram_en), .data_sram_wen(data_sram_wen), .data_sram_addr(data_sram_addr),
    .data_sram_wdata(data_sram_wdata), .data_sram_rdata(n_data_sram_rdata),
    .stallreq_bus(n_stallreq_bus), .bus_req(n_bus_req), .bus_wr(n_bus_wr), .bus_wstrb(n_bus_wstrb),
    .bus_addr(n_bus_addr), .bus_wdata(n_bus_wdata), .bus_addr_ok(bus_addr_ok),
    .bus_rdata(bus_rdata), .bus_data_ok(bus_data_ok)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic step(input logic aok, input logic dok, input logic [31:0] rd);
    @(posedge clk);
    #1;
    bus_addr_ok = aok;
    bus_data_ok = dok;
    bus_rdata   = rd;
  endtask
  initial begin
    #2;
    chk("rst_req", bus_req, 0);
    chk("rst_stall", stallreq_bus, 0);
    chk("rst_addr", bus_addr, 0);
    chk("rst_irdata", inst_sram_rdata, 0);
    chk("rst_drdata", data_sram_rdata, 0);
    chk("rst_wstrb", bus_wstrb, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    // fetch only, cycle 0
    inst_sram_en = 1'b1;
    inst_sram_addr = 32'hBFC0_0000;
    #1;
    chk("f0_stall", stallreq_bus, 1);
    chk("f0_req", bus_req, 0);
    step(0, 0, 0);
    chk("f1_req", bus_req, 1);
    chk("f1_addr", bus_addr, 32'h1FC0_0000);
    chk("f1_addr_nomap", n_bus_addr, 32'hBFC0_0000);
    chk("f1_wr", bus_wr, 0);
    step(0, 0, 0);
    chk("f2_req", bus_req, 1);
    step(1, 0, 0);
    chk("f3_req", bus_req, 1);
    chk("f3_stall", stallreq_bus, 1);
    step(0, 0, 0);
    chk("f4_req", bus_req, 0);
    chk("f4_stall", stallreq_bus, 1);
    step(0, 1, 32'h2408_0001);
    chk("f5_stall", stallreq_bus, 1);
    step(0, 0, 0);
    chk("f6_done_stall", stallreq_bus, 0);
    inst_sram_en = 1'b0;
    step(0, 0, 0);
    chk("f7_irdata", inst_sram_rdata, 32'h2408_0001);
    chk("f7_stall", stallreq_bus, 0);
    // load plus fetch in the same cycle: data first
    data_sram_en = 1'b1;
    data_sram_wen = 4'b0;
    data_sram_addr = 32'h8000_1000;
    inst_sram_en = 1'b1;
    inst_sram_addr = 32'hBFC0_0004;
    #1;
    chk("lf0_stall", stallreq_bus, 1);
    step(1, 0, 0);
    chk("lf1_req", bus_req, 1);
    chk("lf1_addr", bus_addr, 32'h0000_1000);
    chk("lf1_wr", bus_wr, 0);
    step(0, 1, 32'h1234_5678);
    chk("lf2_req", bus_req, 0);
    chk("lf2_stall", stallreq_bus, 1);
    step(1, 0, 0);
    chk("lf3_req", bus_req, 1);
    chk("lf3_addr", bus_addr, 32'h1FC0_0004);
    chk("lf3_drdata", data_sram_rdata, 32'h1234_5678);
    chk("lf3_stall", stallreq_bus, 1);
    step(0, 1, 32'h3C1D_0000);
    chk("lf4_stall", stallreq_bus, 1);
    step(0, 0, 0);
    chk("lf5_done_stall", stallreq_bus, 0);
    data_sram_en = 1'b0;
    inst_sram_en = 1'b0;
    step(0, 0, 0);
    chk("lf6_irdata", inst_sram_rdata, 32'h3C1D_0000);
    chk("lf6_drdata", data_sram_rdata, 32'h1234_5678);
    // store
    data_sram_en = 1'b1;
    data_sram_wen = 4'b0011;
    data_sram_wdata = 32'hAABB_CCDD;
    data_sram_addr = 32'hA000_0010;
    step(1, 0, 0);
    chk("st1_req", bus_req, 1);
    chk("st1_wr", bus_wr, 1);
    chk("st1_wstrb", bus_wstrb, 4'b0011);
    chk("st1_addr", bus_addr, 32'h0000_0010);
    chk("st1_wdata", bus_wdata, 32'hAABB_CCDD);
    step(0, 1, 32'hDEAD_BEEF);
    step(0, 0, 0);
    chk("st3_done_stall", stallreq_bus, 0);
    data_sram_en = 1'b0;
    data_sram_wen = 4'b0;
    step(0, 0, 0);
    chk("st4_drdata", data_sram_rdata, 32'h1234_5678);
    // slow slave, unmapped address, stray data_ok pulses during D_REQ
    data_sram_en = 1'b1;
    data_sram_addr = 32'h0040_0000;
    step(0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      step(0, i[0], 32'h0BAD_0BAD);
      chk("ss_req", bus_req, 1);
      chk("ss_addr", bus_addr, 32'h0040_0000);
      chk("ss_wr", bus_wr, 0);
      chk("ss_stall", stallreq_bus, 1);
    end
    chk("ss_addr_nomap", n_bus_addr, 32'h0040_0000);
    step(1, 0, 0);
    chk("ss_req_ack", bus_req, 1);
    step(0, 1, 32'h55AA_55AA);
    chk("ss_wait_req", bus_req, 0);
    step(0, 0, 0);
    chk("ss_done_stall", stallreq_bus, 0);
    data_sram_en = 1'b0;
    step(0, 0, 0);
    chk("ss_drdata", data_sram_rdata, 32'h55AA_55AA);
    chk("ss_drdata_nomap", n_data_sram_rdata, 32'h55AA_55AA);
    // reset during I_WAIT
    inst_sram_en = 1'b1;
    inst_sram_addr = 32'hBFC0_0008;
    step(1, 0, 0);
    step(0, 0, 0);
    chk("rw_req_pre", bus_req, 0);
    chk("rw_stall_pre", stallreq_bus, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("rw_req", bus_req, 0);
    chk("rw_stall", stallreq_bus, 0);
    chk("rw_irdata", inst_sram_rdata, 0);
    chk("rw_drdata", data_sram_rdata, 0);
    chk("rw_addr", bus_addr, 0);
    chk("rw_state", 32'(dut.state_q), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("rf0_stall", stallreq_bus, 1);
    step(1, 0, 0);
    chk("rf1_req", bus_req, 1);
    chk("rf1_addr", bus_addr, 32'h1FC0_0008);
    step(0, 0, 0);
    step(0, 1, 32'h1111_2222);
    step(0, 0, 0);
    chk("rf_done_stall", stallreq_bus, 0);
    inst_sram_en = 1'b0;
    step(0, 0, 0);
    chk("rf_irdata", inst_sram_rdata, 32'h1111_2222);
    chk("rf_drdata", data_sram_rdata, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/sram_bus_bridge.md
Name: sram_bus_bridge

Overview:
- Sits directly downstream of the CPU core's instruction and data SRAM-style ports and feeds one shared request/acknowledge memory bus.
- Serialises the inst and data requests issued in a cycle and performs kseg0/kseg1 address translation.
- Drives a stall request into the core's stall controller until every request in that cycle is served.
- Returns read data on registered, held outputs, so the core keeps its one-cycle SRAM read timing across stalls.

Parameters:
- KSEG_MAP, 1: when 1, an addr with [31:29] = 3'b100 or 3'b101 has [31:29] cleared on the bus; when 0, addr passes unchanged.

Ports:
- clk  in  1  core clock
- rst  in  1  reset, asynchronous, active-high
- inst_sram_en  in  1  instruction fetch request
- inst_sram_wen  in  4  ignored; fetches are always reads
- inst_sram_addr  in  32  fetch address
- inst_sram_wdata  in  32  ignored
- inst_sram_rdata  out  32  registered, held fetch data
- data_sram_en  in  1  data access request
- data_sram_wen  in  4  byte write strobes; 0 means read
- data_sram_addr  in  32  data address
- data_sram_wdata  in  32  store data
- data_sram_rdata  out  32  registered, held load data
- stallreq_bus  out  1  stall request to the stall controller
- bus_req  out  1  transaction request
- bus_wr  out  1  1 = write
- bus_wstrb  out  4  byte strobes
- bus_addr  out  32  translated address
- bus_wdata  out  32  write data
- bus_addr_ok  in  1  slave accepted the request
- bus_rdata  in  32  read data
- bus_data_ok  in  1  read data valid / write done

Behaviour:
- Clock and reset: one clock, clk; reset rst is asynchronous and active-high.
- Reset values: state IDLE, bus_req 0, bus_wr 0, bus_wstrb 0, bus_addr 0, bus_wdata 0, inst_sram_rdata 0, data_sram_rdata 0, stallreq_bus 0.
- FSM states: IDLE, D_REQ, D_WAIT, I_REQ, I_WAIT, DONE.
- IDLE:
  - data_sram_en → D_REQ; else inst_sram_en → I_REQ; else stay.
  - Data always goes before inst.
- D_REQ:
  - bus_req = 1; bus_addr, bus_wr (= |wen), bus_wstrb and bus_wdata are registered from the core inputs on IDLE exit.
  - All request fields stay stable until bus_addr_ok is sampled high → D_WAIT.
- D_WAIT:
  - bus_req = 0.
  - On bus_data_ok: a read loads data_sram_rdata from bus_rdata; a write leaves it unchanged.
  - Then go to I_REQ if inst_sram_en, else DONE.
- I_REQ / I_WAIT:
  - Same sequence with bus_wr = 0 and bus_wstrb = 0.
  - On bus_data_ok, inst_sram_rdata ← bus_rdata, then DONE.
- DONE: lasts one cycle, then IDLE. In IDLE, the next cycle's requests are treated as new, so a held PC is refetched harmlessly.
- stallreq_bus:
  - = (state == IDLE && (inst_sram_en || data_sram_en)) || (state ∉ {IDLE, DONE}).
  - Combinational from the en inputs only in IDLE; forced 0 while rst is high.
  - Deasserts exactly in the DONE cycle.
- Core-facing timing:
  - The core holds en, addr, wen and wdata stable while stalled; the bridge resamples nothing after IDLE exit.
  - The rdata registers change only on a matching bus_data_ok. Values are visible the cycle after DONE and held indefinitely.
- Bus rules:
  - One outstanding transaction.
  - bus_data_ok is ignored outside the *_WAIT states.
  - The slave never returns data_ok in the same cycle as addr_ok.
  - bus_addr_ok is ignored outside the *_REQ states.
- Address translation is applied combinationally before the IDLE-exit register; no other arithmetic.
- Reset mid-transaction: immediate return to IDLE with all outputs at their reset values. The slave's outstanding response is dropped by the system reset.
- Simultaneous inst and data requests cost two bus transactions plus one DONE cycle.

Test Plan:
- Fetch only: inst_sram_en = 1, addr 0xBFC00000 → bus_addr 0x1FC00000, bus_req held until addr_ok. With addr_ok at cycle 3 and data_ok at cycle 5 (rdata 0x24080001): stallreq high cycles 0–5, DONE at cycle 6, inst_sram_rdata = 0x24080001 from cycle 7.
- Load plus fetch in one cycle: data addr 0x80001000 read first (bus_addr 0x00001000, returns 0x12345678), then inst → data_sram_rdata = 0x12345678 and inst_sram_rdata updated; stallreq deasserts only in DONE.
- Store: data_sram_wen = 4'b0011, wdata 0xAABBCCDD, addr 0xA0000010 → bus_wr 1, wstrb 0011, addr 0x00000010; data_sram_rdata unchanged.
- KSEG_MAP = 0: addr 0xBFC00000 → bus_addr 0xBFC00000; addr 0x00400000 unaffected in both modes.
- Slow slave: addr_ok delayed 10 cycles, with data_ok pulses injected in D_REQ → pulses ignored, request fields stable, stallreq continuous.
- Reset asserted during I_WAIT → async: bus_req 0, stallreq 0, rdata regs 0, state IDLE; after release, a fresh fetch completes normally.
